data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter_if.sv | 61 ++++++
 rtl/data_memory_arbiter.sv | 128 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - bus bundle between two requesters, the clear control and the data memory
//
// Purpose: carries every non-clock signal of data_memory_arbiter.
// Signals:
//   clear_start / clear_busy             clear request pulse / sequencer owns memory
//   pN_req, pN_we, pN_addr, pN_wdata     request from port N (0 = core, 1 = loader/DMA)
//   pN_gnt                               combinational grant, access happens this cycle
//   pN_rvalid, pN_rdata                  registered read return, one cycle after grant
//   mem_addr, mem_wdata, mem_we          memory address/write port
//   mem_rdata                            asynchronous memory read data at mem_addr
// Modports: slave = arbiter side, master = requester/memory side.
interface data_memory_arbiter_if #(
  parameter int D_ADDR_W = 12,
  parameter int DATA_W   = 8
);
  logic                clear_start;
  logic                clear_busy;

  logic                p0_req;
  logic                p0_we;
  logic [D_ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0]   p0_wdata;
  logic                p0_gnt;
  logic                p0_rvalid;
  logic [DATA_W-1:0]   p0_rdata;

  logic                p1_req;
  logic                p1_we;
  logic [D_ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0]   p1_wdata;
  logic                p1_gnt;
  logic                p1_rvalid;
  logic [DATA_W-1:0]   p1_rdata;

  logic [D_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  clear_start,
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output clear_busy,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output clear_start,
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  clear_busy,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port round-robin data memory arbiter with memory clear sequencer
//
// Purpose: shares one asynchronous-read data memory between port 0 (core) and
// port 1 (loader/DMA). After reset, or on clear_start, a sequencer writes zero
// to every word before arbitration resumes.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    data_memory_arbiter_if.slave (requests, grants, read returns, memory port)
module data_memory_arbiter #(
  parameter int D_ADDR_W       = 12,
  parameter int DATA_W         = 8,
  parameter int D_MEMORY_DEPTH = 1 << D_ADDR_W
) (
  input logic                   clk,
  input logic                   rst_n,
  data_memory_arbiter_if.slave  bus
);

  // One extra bit so a full 2^D_ADDR_W clear never wraps the counter.
  localparam int                CNT_W     = D_ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(D_MEMORY_DEPTH - 1);

  typedef enum logic {CLEAR, ARB} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fav1_q, fav1_d;   // 1 = port 1 wins a tie
  logic                gnt0, gnt1;
  logic                clear_busy;
  logic                mem_we;
  logic [D_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      fav1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fav1_q    <= fav1_d;
      rvalid0_q <= gnt0 & ~bus.p0_we;
      rvalid1_q <= gnt1 & ~bus.p1_we;
      if (gnt0 && !bus.p0_we) rdata0_q <= bus.mem_rdata;
      if (gnt1 && !bus.p1_we) rdata1_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fav1_d     = fav1_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    clear_busy = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      CLEAR: begin
        // clear_start is deliberately not looked at here: a running clear is never restarted.
        clear_busy = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = cnt_q[D_ADDR_W-1:0];
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CLR_LAST) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      ARB: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (bus.p0_req && (!bus.p1_req || !fav1_q)) begin
          gnt0 = 1'b1;
        end else if (bus.p1_req) begin
          gnt1 = 1'b1;
        end

        if (gnt0) begin
          mem_we    = bus.p0_we;
          mem_addr  = bus.p0_addr;
          mem_wdata = bus.p0_wdata;
          fav1_d    = 1'b1;
        end else if (gnt1) begin
          mem_we    = bus.p1_we;
          mem_addr  = bus.p1_addr;
          mem_wdata = bus.p1_wdata;
          fav1_d    = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase

    // While reset is held the state may not have reached CLEAR yet; keep
    // requesters and the memory quiet and report the memory as busy.
    if (!rst_n) begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      clear_busy = 1'b1;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  assign bus.clear_busy = clear_busy;
  assign bus.p0_gnt     = gnt0;
  assign bus.p1_gnt     = gnt1;
  assign bus.p0_rvalid  = rvalid0_q;
  assign bus.p1_rvalid  = rvalid1_q;
  assign bus.p0_rdata   = rdata0_q;
  assign bus.p1_rdata   = rdata1_q;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking scoreboard bench for data_memory_arbiter
module tb_data_memory_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.D_ADDR_W(AW), .DATA_W(DW)) bus ();

  data_memory_arbiter #(
    .D_ADDR_W      (AW),
    .DATA_W        (DW),
    .D_MEMORY_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Memory with asynchronous read; refilled with garbage during reset so the clear is visible.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hEE;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = ram[bus.mem_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected read returns per port, with the cycle they are due.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;
  rd_t           q0[$];
  rd_t           q1[$];
  logic [DW-1:0] model [DEPTH];
  logic          e0, e1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    end else if (bus.clear_start && !bus.clear_busy) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    end

    e0 = (q0.size() > 0) && (q0[0].due <= cyc);
    if (e0 || bus.p0_rvalid) begin
      check("p0_rvalid", bus.p0_rvalid, e0);
      if (e0) begin
        check("p0_rdata", bus.p0_rdata, q0[0].data);
        void'(q0.pop_front());
      end
    end
    e1 = (q1.size() > 0) && (q1[0].due <= cyc);
    if (e1 || bus.p1_rvalid) begin
      check("p1_rvalid", bus.p1_rvalid, e1);
      if (e1) begin
        check("p1_rdata", bus.p1_rdata, q1[0].data);
        void'(q1.pop_front());
      end
    end

    if (bus.p0_gnt || bus.p1_gnt) check("gnt_onehot", bus.p0_gnt & bus.p1_gnt, 1'b0);
    if (bus.p0_gnt) begin
      if (bus.p0_we) model[bus.p0_addr] = bus.p0_wdata;
      else q0.push_back('{data: model[bus.p0_addr], due: cyc + 1});
    end else if (bus.p1_gnt) begin
      if (bus.p1_we) model[bus.p1_addr] = bus.p1_wdata;
      else q1.push_back('{data: model[bus.p1_addr], due: cyc + 1});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.p0_req      = 1'b0;
    bus.p1_req      = 1'b0;
    bus.clear_start = 1'b0;
  endtask

  task automatic set_p(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end
  endtask

  task automatic expect_gnt(input string tag, input logic g0, input logic g1);
    @(negedge clk);
    check({tag, "_gnt0"}, bus.p0_gnt, g0);
    check({tag, "_gnt1"}, bus.p1_gnt, g1);
  endtask

  // Expects to be called in the first clear cycle; ends at the negedge of the first ARB cycle.
  task automatic check_clear(input string tag, input int pulse_at);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check($sformatf("%s_ctl%0d", tag, i),
            {bus.clear_busy, bus.mem_we, bus.p0_gnt, bus.p1_gnt}, 4'b1100);
      check($sformatf("%s_addr%0d", tag, i), bus.mem_addr, i);
      check($sformatf("%s_wdata%0d", tag, i), bus.mem_wdata, 0);
      if (i == pulse_at) bus.clear_start = 1'b1;
      if (i == pulse_at + 1) bus.clear_start = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done"}, bus.clear_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    rst_n = 1'b0;
    tick(); tick();

    // Reset state
    @(negedge clk);
    check("rst_busy", bus.clear_busy, 1'b1);
    check("rst_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b00);
    check("rst_rvalid", {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
    check("rst_rdata0", bus.p0_rdata, 0);
    check("rst_rdata1", bus.p1_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear("clr0", -1);
    tick();

    // Write then read back, read of an untouched cleared word, back-to-back on port 0
    set_p(0, 1'b1, 4'd3, 8'hA5); expect_gnt("wr3", 1'b1, 1'b0); tick();
    set_p(0, 1'b0, 4'd3, 8'h00); expect_gnt("rd3", 1'b1, 1'b0); tick();
    set_p(0, 1'b0, 4'd4, 8'h00); expect_gnt("rd4", 1'b1, 1'b0); tick();
    idle();
    // Port 1 access leaves port 0 favoured for the tie test
    set_p(1, 1'b0, 4'd3, 8'h00); expect_gnt("p1rd3", 1'b0, 1'b1); tick();
    idle();
    tick();

    // Round-robin under sustained contention
    set_p(0, 1'b0, 4'd3, 8'h00);
    set_p(1, 1'b0, 4'd4, 8'h00);
    for (int k = 0; k < 4; k++) begin
      expect_gnt($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
      tick();
    end
    idle();
    tick();

    // Same-cycle read (p0) and write (p1) to one address
    set_p(0, 1'b0, 4'd7, 8'h00);
    set_p(1, 1'b1, 4'd7, 8'h3C);
    expect_gnt("wr_rd_a", 1'b1, 1'b0); tick();
    bus.p0_req = 1'b0;
    expect_gnt("wr_rd_b", 1'b0, 1'b1); tick();
    idle();
    set_p(0, 1'b0, 4'd7, 8'h00); expect_gnt("rd7", 1'b1, 1'b0); tick();
    idle();
    tick();

    // clear_start with a pending request; a second pulse mid-clear is ignored
    set_p(0, 1'b0, 4'd3, 8'h00);
    bus.clear_start = 1'b1;
    expect_gnt("clr_req", 1'b0, 1'b0);
    tick();
    bus.clear_start = 1'b0;
    check_clear("clr1", 5);
    check("clr1_gnt0", bus.p0_gnt, 1'b1);
    tick();
    idle();
    tick();

    // Reset at the edge ending a read grant drops the return
    set_p(0, 1'b1, 4'd3, 8'h5A); expect_gnt("wr3b", 1'b1, 1'b0); tick();
    set_p(0, 1'b0, 4'd3, 8'h00); expect_gnt("rd3b", 1'b1, 1'b0); tick();
    set_p(0, 1'b0, 4'd3, 8'h00); expect_gnt("rst_rd", 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    check("rst2_rvalid", bus.p0_rvalid, 1'b0);
    check("rst2_rdata", bus.p0_rdata, 0);
    check("rst2_busy", bus.clear_busy, 1'b1);
    check("rst2_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear("clr2", -1);
    tick(); tick();
    check("sb_empty", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
